// File: rtl/ofifo_drain_pkg.sv
// Shared types and constants for the output-FIFO drain path and the accumulate stage.
package ofifo_drain_pkg;

    localparam int unsigned COL_DEF     = 8;
    localparam int unsigned PSUM_BW_DEF = 16;
    localparam int unsigned ADDR_BW_DEF = 11;
    localparam int unsigned CNT_BW_DEF  = 11;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StFlush = 2'd2,
        StDone  = 2'd3
    } state_e;

    // SRAM strobes are active-low
    localparam logic CEN_ON  = 1'b0;
    localparam logic CEN_OFF = 1'b1;
    localparam logic WEN_WR  = 1'b0;
    localparam logic WEN_RD  = 1'b1;

endpackage

// File: rtl/ofifo_drain_if.sv
// Control, FIFO-read and SRAM-write signals of the drain block bundled as one interface.
interface ofifo_drain_if
    import ofifo_drain_pkg::*;
#(
    parameter int unsigned col     = COL_DEF,
    parameter int unsigned psum_bw = PSUM_BW_DEF,
    parameter int unsigned addr_bw = ADDR_BW_DEF,
    parameter int unsigned cnt_bw  = CNT_BW_DEF
) ();

    logic                   start;
    logic [addr_bw-1:0]     base_addr;
    logic [cnt_bw-1:0]      num_rows;
    logic                   ofifo_valid;
    logic                   ofifo_rd;
    logic [psum_bw*col-1:0] ofifo_out;
    logic                   sram_cen;
    logic                   sram_wen;
    logic [addr_bw-1:0]     sram_addr;
    logic [psum_bw*col-1:0] sram_d;
    logic                   busy;
    logic                   done;

    modport slave (
        input  start, base_addr, num_rows, ofifo_valid, ofifo_out,
        output ofifo_rd, sram_cen, sram_wen, sram_addr, sram_d, busy, done
    );

    modport master (
        output start, base_addr, num_rows, ofifo_valid, ofifo_out,
        input  ofifo_rd, sram_cen, sram_wen, sram_addr, sram_d, busy, done
    );

endinterface

// File: rtl/ofifo_drain.sv
// Pops rows from the output FIFO and writes them to consecutive psum SRAM addresses.
// Optional stall counter output enabled by OFIFO_DRAIN_STALL_CNT_EN.
module ofifo_drain
    import ofifo_drain_pkg::*;
#(
    parameter int unsigned col     = COL_DEF,
    parameter int unsigned psum_bw = PSUM_BW_DEF,
    parameter int unsigned addr_bw = ADDR_BW_DEF,
    parameter int unsigned cnt_bw  = CNT_BW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    ofifo_drain_if.slave  bus_io
`ifdef OFIFO_DRAIN_STALL_CNT_EN
    ,
    output logic [31:0]   stall_cnt
`endif
);

    state_e             state_q, state_d;
    logic [cnt_bw-1:0]  rd_left_q, rd_left_d;
    logic [addr_bw-1:0] wr_addr_q, wr_addr_d;
    logic               pend_q, pend_d;
    logic               pop;
    logic               start_ok;

    assign start_ok = (state_q == StIdle) && bus_io.start;

    always_comb begin
        state_d   = state_q;
        rd_left_d = rd_left_q;
        wr_addr_d = pend_q ? wr_addr_q + addr_bw'(1) : wr_addr_q;
        pop       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_ok) begin
                    wr_addr_d = bus_io.base_addr;
                    if (bus_io.num_rows == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d   = StRun;
                        rd_left_d = bus_io.num_rows;
                    end
                end
            end
            StRun: begin
                pop = bus_io.ofifo_valid && (rd_left_q != '0);
                if (pop) begin
                    rd_left_d = rd_left_q - cnt_bw'(1);
                    if (rd_left_q == cnt_bw'(1)) state_d = StFlush;
                end
            end
            StFlush: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        pend_d = pop;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            rd_left_q <= '0;
            wr_addr_q <= '0;
            pend_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_left_q <= rd_left_d;
            wr_addr_q <= wr_addr_d;
            pend_q    <= pend_d;
        end
    end

    // Write stage follows the pop by one cycle, when the FIFO data is on ofifo_out
    always_comb begin
        bus_io.ofifo_rd  = pop;
        bus_io.busy      = (state_q == StRun) || (state_q == StFlush);
        bus_io.done      = (state_q == StDone);
        bus_io.sram_cen  = pend_q ? CEN_ON : CEN_OFF;
        bus_io.sram_wen  = pend_q ? WEN_WR : WEN_RD;
        bus_io.sram_addr = pend_q ? wr_addr_q : '0;
        bus_io.sram_d    = pend_q ? bus_io.ofifo_out : '0;
    end

`ifdef OFIFO_DRAIN_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (start_ok) begin
            stall_cnt_d = '0;
        end else if ((state_q == StRun) && !bus_io.ofifo_valid && (rd_left_q != '0)
                     && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) stall_cnt_q <= '0;
        else       stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/ofifo_drain.md
Name: ofifo_drain

Overview:
Reader side of the output FIFO that the post-MAC accumulate/activation stage writes into.
- On a start pulse, pops a programmed number of full rows (col words × psum_bw) from the output FIFO.
- Writes each row into the psum SRAM at consecutive addresses from a base address.
- Sustains one row per cycle when the FIFO has data, then signals completion.

Parameters:
col, 8, number of array columns / words per row
psum_bw, 16, bits per psum word
addr_bw, 11, SRAM address width
cnt_bw, 11, width of the row-count input

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
start  input  1  one-cycle pulse, latches base_addr and num_rows; ignored unless idle
base_addr  input  addr_bw  first SRAM row address
num_rows  input  cnt_bw  rows to drain; 0 means finish immediately
ofifo_valid  input  1  FIFO holds at least one full row (all columns non-empty)
ofifo_rd  output  1  pop one row; FIFO data appears on ofifo_out next cycle
ofifo_out  input  psum_bw*col  FIFO row data, valid the cycle after ofifo_rd
sram_cen  output  1  SRAM chip enable, active-low
sram_wen  output  1  SRAM write enable, active-low
sram_addr  output  addr_bw  SRAM address
sram_d  output  psum_bw*col  SRAM write data
busy  output  1  high from the cycle after start until done
done  output  1  one-cycle pulse when the last write has been issued

Behaviour:
- Reset values: ofifo_rd=0, sram_cen=1, sram_wen=1, sram_addr=0, sram_d=0, busy=0, done=0, state=IDLE, counters=0.
- Reset is synchronous. Asserting it mid-transfer aborts immediately: no done pulse; rows already popped are lost.
- State IDLE:
  - start with num_rows>0 → RUN; rd_left=num_rows, wr_addr=base_addr.
  - start with num_rows=0 → DONE.
- State RUN:
  - ofifo_rd = ofifo_valid && rd_left!=0, driven combinationally.
  - Each pop decrements rd_left.
  - A pop sets the registered flag pend=1 for the next cycle.
  - When rd_left reaches 0 after a pop → FLUSH.
- Write stage, active in any state when pend=1:
  - sram_cen=0, sram_wen=0, sram_d=ofifo_out, sram_addr=wr_addr.
  - wr_addr increments after the write.
  - SRAM outputs are driven combinationally from pend, wr_addr and ofifo_out, so the SRAM samples them at the next edge.
- Latency: pop in cycle N → SRAM write strobe in cycle N+1 → SRAM captures at the edge ending N+1.
- Throughput: back-to-back pops allowed, giving one row per cycle.
- Stalls: ofifo_valid low in RUN inserts a bubble. No pop, and pend is 0 the next cycle.
- State FLUSH: entered with the final pend=1. Completes that write → DONE.
- State DONE: done=1 for one cycle, busy=0 → IDLE.
- busy is high in RUN and FLUSH.
- start while busy or in DONE is ignored.
- wr_addr wraps modulo 2^addr_bw; no error is flagged.
- sram_cen/sram_wen return to 1 on every cycle with no write.

Optional Feature:
- Macro: OFIFO_DRAIN_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt (32 bits).
  - Counts RUN cycles with ofifo_valid=0 and rd_left!=0.
  - Cleared on reset and on an accepted start; saturates at all ones.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - State encoding IDLE/RUN/FLUSH/DONE (2-bit).
  - SRAM active-low constants CEN_ON=0, CEN_OFF=1, WEN_WR=0, WEN_RD=1.
  - Default col/psum_bw values shared with the accumulate stage.
- No sub-module is needed. The address/row counter may be split out as ofifo_drain_ctr only if it is reused by the SRAM read-side loader.

Test Plan:
- Basic drain: base_addr=0x010, num_rows=4, ofifo_valid always 1 with rows R0..R3.
  → ofifo_rd high 4 consecutive cycles.
  → writes to 0x010..0x013 with R0..R3, one cycle after each pop.
  → done one cycle after the last write; busy high 5 cycles.
- Stall: num_rows=3, ofifo_valid pattern 1,0,0,1,1.
  → writes at 0x000, 0x001, 0x002 with two bubbles (sram_cen=1).
  → stall_cnt=2 when OFIFO_DRAIN_STALL_CNT_EN is defined.
- Zero rows: start with num_rows=0.
  → no ofifo_rd, no write; done pulses the cycle after start.
- Wrap: addr_bw=11, base_addr=0x7FF, num_rows=2.
  → writes to 0x7FF then 0x000.
- Ignored restart: second start pulse mid-RUN with a different base_addr.
  → original sequence continues unchanged.
- Reset mid-transfer: reset asserted after 2 of 5 pops.
  → next cycle all outputs at reset values, no done.
  → a fresh start works normally.
